// File: rtl/cla_seq_32b.sv
// cla_seq_32b: byte-serial 32-bit add/subtract built around one shared cla_8b slice.
// Latency: start sampled at E0, bytes 0..3 on E1..E4, data_resultRDY pulses in the cycle after E4.
// Backpressure: none; ctrl_start is accepted only in IDLE/DONE and is dropped (not queued) while busy.
//
// Ports:
//   clock, reset                  single rising-edge clock, synchronous active-high reset
//   ctrl_start, ctrl_sub          request and operation select (0 = A+B, 1 = A-B)
//   data_operandA/B               32-bit operands, latched with ctrl_start
//   data_result, carry_out,       registered result and flags, held until the next
//   overflow, isNotEqual,         completion or reset
//   isLessThan
//   busy, data_resultRDY          busy while bytes are processed; one-cycle completion pulse
//
// Configuration macro: CLA_SEQ_CMP_EN. When defined, isNotEqual/isLessThan report the
// compare result of a subtraction; when undefined both are tied to 0 with no compare logic.

module cla_8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] out,
    output logic       G0,
    output logic       P0,
    output logic       c_msb
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_c;
    logic       w_grp_g;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Per-bit carries and the group generate/propagate; written as a prefix chain,
    // synthesis is free to flatten it into a lookahead tree.
    always_comb begin
        w_c     = '0;
        w_grp_g = 1'b0;
        w_c[0]  = c_in;
        for (int i = 0; i < 7; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        for (int i = 0; i < 8; i++) begin
            w_grp_g = w_g[i] | (w_p[i] & w_grp_g);
        end
    end

    assign out   = w_p ^ w_c;
    assign G0    = w_grp_g;
    assign P0    = &w_p;
    assign c_msb = w_c[7];
endmodule

module cla_seq_32b (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic        ctrl_sub,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        carry_out,
    output logic        overflow,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        busy,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_k;
    logic        r_carry;
    logic [31:0] r_a;
    logic [31:0] r_b;          // already inverted for subtraction
    logic [23:0] r_acc;        // bytes 0..2; byte 3 goes straight to the result
    logic [31:0] r_result;
    logic        r_carry_out;
    logic        r_overflow;
    logic        r_busy;
    logic        r_rdy;

    logic [7:0]  w_a_byte;
    logic [7:0]  w_b_byte;
    logic [7:0]  w_out;
    logic        w_g0;
    logic        w_p0;
    logic        w_c_msb;
    logic        w_cout;
    logic        w_ovf;

    always_comb begin
        w_a_byte = r_a[7:0];
        w_b_byte = r_b[7:0];
        case (r_k)
            2'd0: begin w_a_byte = r_a[7:0];   w_b_byte = r_b[7:0];   end
            2'd1: begin w_a_byte = r_a[15:8];  w_b_byte = r_b[15:8];  end
            2'd2: begin w_a_byte = r_a[23:16]; w_b_byte = r_b[23:16]; end
            default: begin w_a_byte = r_a[31:24]; w_b_byte = r_b[31:24]; end
        endcase
    end

    cla_8b u_slice (
        .a     (w_a_byte),
        .b     (w_b_byte),
        .c_in  (r_carry),
        .out   (w_out),
        .G0    (w_g0),
        .P0    (w_p0),
        .c_msb (w_c_msb)
    );

    assign w_cout = w_g0 | (w_p0 & r_carry);
    // Signed overflow: carry into bit 31 differs from carry out of bit 31.
    assign w_ovf  = w_c_msb ^ w_cout;

`ifdef CLA_SEQ_CMP_EN
    logic r_sub;
    logic r_ne_acc;            // OR of result bytes produced so far
    logic r_is_ne;
    logic r_is_lt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k         <= 2'd0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b0;
`ifdef CLA_SEQ_CMP_EN
            r_sub       <= 1'b0;
            r_ne_acc    <= 1'b0;
            r_is_ne     <= 1'b0;
            r_is_lt     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_RUN: begin
                    r_carry <= w_cout;
                    r_k     <= r_k + 2'd1;
`ifdef CLA_SEQ_CMP_EN
                    r_ne_acc <= r_ne_acc | (|w_out);
`endif
                    case (r_k)
                        2'd0: r_acc[7:0]   <= w_out;
                        2'd1: r_acc[15:8]  <= w_out;
                        2'd2: r_acc[23:16] <= w_out;
                        default: begin
                            r_result    <= {w_out, r_acc};
                            r_carry_out <= w_cout;
                            r_overflow  <= w_ovf;
                            r_busy      <= 1'b0;
                            r_rdy       <= 1'b1;
                            r_state     <= S_DONE;
`ifdef CLA_SEQ_CMP_EN
                            r_is_ne <= r_sub & (r_ne_acc | (|w_out));
                            r_is_lt <= r_sub & (w_out[7] ^ w_ovf);
`endif
                        end
                    endcase
                end
                default: begin
                    // IDLE and DONE behave alike except DONE falls back to IDLE.
                    r_rdy <= 1'b0;
                    if (ctrl_start) begin
                        r_a     <= data_operandA;
                        r_b     <= ctrl_sub ? ~data_operandB : data_operandB;
                        r_carry <= ctrl_sub;
                        r_k     <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`ifdef CLA_SEQ_CMP_EN
                        r_sub    <= ctrl_sub;
                        r_ne_acc <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign carry_out      = r_carry_out;
    assign overflow       = r_overflow;
    assign busy           = r_busy;
    assign data_resultRDY = r_rdy;
`ifdef CLA_SEQ_CMP_EN
    assign isNotEqual     = r_is_ne;
    assign isLessThan     = r_is_lt;
`else
    assign isNotEqual     = 1'b0;
    assign isLessThan     = 1'b0;
`endif
endmodule

// File: tb/tb_cla_seq_32b.sv
module tb_cla_seq_32b;
    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic        ctrl_sub;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        carry_out;
    logic        overflow;
    logic        isNotEqual;
    logic        isLessThan;
    logic        busy;
    logic        data_resultRDY;

    cla_seq_32b dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_sub       (ctrl_sub),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .carry_out      (carry_out),
        .overflow       (overflow),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .busy           (busy),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef CLA_SEQ_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Operation-level view: an accepted request finishes 4 edges later; results held.
    int          m_left = 0;
    logic        m_rdy  = 1'b0;
    logic [31:0] m_res  = '0;
    logic        m_co   = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_ne   = 1'b0;
    logic        m_lt   = 1'b0;
    logic [31:0] p_res;
    logic        p_co, p_ovf, p_ne, p_lt;

    task automatic compute(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] wide;
        if (sub) begin
            p_res = a - b;
            p_co  = (a >= b);
            p_ovf = (a[31] != b[31]) && (p_res[31] != a[31]);
            p_ne  = CMP && (a != b);
            p_lt  = CMP && ($signed(a) < $signed(b));
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            p_res = wide[31:0];
            p_co  = wide[32];
            p_ovf = (a[31] == b[31]) && (p_res[31] != a[31]);
            p_ne  = 1'b0;
            p_lt  = 1'b0;
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_left = 0; m_rdy = 0; m_res = 0; m_co = 0; m_ovf = 0; m_ne = 0; m_lt = 0;
        end else begin
            m_rdy = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = p_res; m_co = p_co; m_ovf = p_ovf; m_ne = p_ne; m_lt = p_lt;
                    m_rdy = 1'b1;
                end
            end else if (ctrl_start) begin
                compute(data_operandA, data_operandB, ctrl_sub);
                m_left = 4;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        while (!done) begin
            @(negedge clock);
            if (chk_en && !done) begin
                check("busy",       {31'd0, busy},           {31'd0, m_left > 0});
                check("rdy",        {31'd0, data_resultRDY}, {31'd0, m_rdy});
                check("result",     data_result,             m_res);
                check("carry_out",  {31'd0, carry_out},      {31'd0, m_co});
                check("overflow",   {31'd0, overflow},       {31'd0, m_ovf});
                check("isNotEqual", {31'd0, isNotEqual},     {31'd0, m_ne});
                check("isLessThan", {31'd0, isLessThan},     {31'd0, m_lt});
            end
        end
    end

    // ---------------- directed op with literal expectations ----------------
    // Called at a negedge; returns at the negedge where RDY is seen (the DONE cycle).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input bit poke, input string tag,
                          input logic [31:0] e_res, input logic e_co, input logic e_ovf,
                          input logic e_ne, input logic e_lt);
        int cyc;
        ctrl_start = 1'b1; ctrl_sub = sub; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_start = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        cyc = 1;
        while (!data_resultRDY && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (poke && cyc == 2) begin
                ctrl_start = 1'b1; ctrl_sub = ~sub;
                data_operandA = $urandom; data_operandB = $urandom;
            end else begin
                ctrl_start = 1'b0;
            end
        end
        check({tag, "_latency"},  cyc,                       32'd5);
        check({tag, "_result"},   data_result,               e_res);
        check({tag, "_carry"},    {31'd0, carry_out},        {31'd0, e_co});
        check({tag, "_overflow"}, {31'd0, overflow},         {31'd0, e_ovf});
        check({tag, "_ne"},       {31'd0, isNotEqual},       {31'd0, e_ne & CMP});
        check({tag, "_lt"},       {31'd0, isLessThan},       {31'd0, e_lt & CMP});
    endtask

    task automatic idle(input int n);
        ctrl_start = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return {24'd0, 8'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int rdy_seen;
        reset = 1'b1; ctrl_start = 1'b0; ctrl_sub = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(negedge clock);
        // Reset state
        check("rst_result", data_result, 32'd0);
        check("rst_flags",  {26'd0, carry_out, overflow, isNotEqual, isLessThan, busy, data_resultRDY}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Directed ops, issued back-to-back (each start lands in the previous DONE cycle)
        run_op(32'h0000_00FF, 32'h1, 1'b0, 1'b0, "bytecarry", 32'h0000_0100, 0, 0, 0, 0);
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "sovf",      32'h8000_0000, 0, 1, 0, 0);
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "wrap",      32'h0000_0000, 1, 0, 0, 0);
        run_op(32'd5,         32'd7, 1'b1, 1'b0, "lt",        32'hFFFF_FFFE, 0, 0, 1, 1);
        run_op(32'd7,         32'd7, 1'b1, 1'b0, "eq",        32'h0000_0000, 1, 0, 0, 0);
        run_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, "minsub",    32'h7FFF_FFFF, 1, 1, 1, 1);
        idle(3);
        // Start while busy: a second start and new operands mid-run are ignored
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, "poke", 32'h2345_6789, 0, 0, 0, 0);
        idle(1);
        check("poke_no_extra_busy", {31'd0, busy}, 32'd0);

        // Reset mid-op: reset applied so it is sampled at E2
        ctrl_start = 1'b1; ctrl_sub = 1'b0; data_operandA = 32'd100; data_operandB = 32'd23;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid_busy",   {31'd0, busy},           32'd0);
        check("rstmid_result", data_result,             32'd0);
        rdy_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("rstmid_no_rdy", rdy_seen, 32'd0);
        // Reset and start together: request dropped
        reset = 1'b1; ctrl_start = 1'b1;
        @(negedge clock);
        reset = 1'b0; ctrl_start = 1'b0;
        check("rststart_busy", {31'd0, busy}, 32'd0);
        idle(1);
        run_op(32'd100, 32'd23, 1'b1, 1'b0, "after_rst", 32'd77, 1, 0, 1, 0);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            ctrl_start    = ($urandom_range(0, 99) < 60);
            ctrl_sub      = $urandom_range(0, 1);
            data_operandA = rand_opnd();
            data_operandB = ($urandom_range(0, 7) == 0) ? data_operandA : rand_opnd();
            @(negedge clock);
        end
        reset = 1'b0; ctrl_start = 1'b0;
        idle(8);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
